fmap_pingpong_buffer: RTL
=========================

Name: fmap_pingpong_buffer

Overview:
- Double-banked feature-map buffer that serves tensor data to a conv2d-style engine.
- A streaming producer (valid/ready) fills one bank while the consumer reads the other bank through the conv2d input-memory interface (input_en/input_addr -> input_data).
- Banks swap under a consume_done handshake, so loading of layer N+1 overlaps computation of layer N inside resblock-type pipelines.

Parameters:
- DATA_WIDTH, 32, element width in bits
- ADDR_WIDTH, 16, consumer address width
- DEPTH, 512, elements per bank (BATCH_SIZE*CHANNELS*HEIGHT*WIDTH); DEPTH >= 2, DEPTH <= 2**ADDR_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  producer word valid
- load_data  in  DATA_WIDTH  producer word, element order = flat tensor index
- load_ready  out  1  buffer can accept load_data this cycle
- rd_en  in  1  consumer read enable (conv2d input_en)
- rd_addr  in  ADDR_WIDTH  consumer element address (conv2d input_addr)
- rd_data  out  DATA_WIDTH  consumer read data (conv2d input_data), combinational
- bank_ready  out  1  consumer bank holds a complete tensor
- consume_done  in  1  single-cycle pulse: consumer finished with the current bank
- fill_count  out  ADDR_WIDTH  words accepted so far into the filling bank
- banks_full  out  2  number of full banks (0..2)
- err  out  1  sticky protocol error

Behaviour:
- State:
  - mem[2][DEPTH]
  - wp_bank (fill pointer)
  - rp_bank (consume pointer)
  - full[1:0]
  - fill_cnt
  - err
- Reset (rst_n low, asynchronous):
  - Registers cleared: wp_bank=0, rp_bank=0, full=00, fill_cnt=0, err=0.
  - Outputs while in reset: load_ready=1, bank_ready=0, rd_data=0, fill_count=0, banks_full=0.
  - Memory contents are not reset.
  - Reset mid-fill discards the partial bank; reset mid-consume discards both banks.
- Per-bank states: EMPTY -> FILLING (fill_cnt > 0, bank = wp_bank) -> FULL -> CONSUMING (bank = rp_bank, bank_ready=1) -> EMPTY.
- Load:
  - load_ready = !full[wp_bank] (registered state only; no combinational path from load_valid).
  - Transfer occurs when load_valid & load_ready: mem[wp_bank][fill_cnt] <= load_data, fill_cnt++.
  - When the transfer is at fill_cnt==DEPTH-1, the bank completes: fill_cnt<=0, full[wp_bank]<=1, wp_bank toggles.
  - After completion, load_ready is re-evaluated against the new wp_bank: 1 if that bank is empty, else 0.
  - A full buffer (both banks full) holds load_ready=0. load_data is ignored when there is no transfer.
- Consume:
  - bank_ready = full[rp_bank]. It rises the cycle after the final word of that bank is accepted (1-cycle latency).
  - rd_data = mem[rp_bank][rd_addr] when rd_en & bank_ready & rd_addr < DEPTH, else 0. Zero-latency combinational read, matching conv2d timing.
  - rd_en with !bank_ready, or rd_addr >= DEPTH: rd_data=0 and err<=1.
  - consume_done with bank_ready: full[rp_bank]<=0, rp_bank toggles.
  - consume_done with !bank_ready: ignored, err<=1.
  - Reads of an address in the cycle consume_done is asserted still return the old bank.
- Simultaneous events:
  - A final-word load and a consume_done in the same cycle always target different banks. Both take effect; banks_full is unchanged net.
  - A non-final load and a consume_done in the same cycle are independent.
- banks_full = full[0] + full[1]. fill_count = fill_cnt.
- err is cleared only by reset.
- Wrap-around: wp_bank and rp_bank are 1-bit toggles. fill_cnt never exceeds DEPTH-1.

Test Plan (DEPTH=4, DATA_WIDTH=32):
- Reset then idle -> load_ready=1, bank_ready=0, rd_data=0, banks_full=0, err=0.
- Stream 1,2,3,4 with load_valid held high -> fill_count 0,1,2,3,0; bank_ready=1 the cycle after word 4; rd_addr=0..3 with rd_en -> rd_data 1,2,3,4; banks_full=1; load_ready stays 1.
- Fill bank0 (1..4) and bank1 (5..8) with no consume_done -> load_ready=0, banks_full=2, extra load_valid word 9 not accepted. Pulse consume_done -> next cycle rd_addr=1 returns 6 and load_ready=1.
- Accept word 4 of bank1 and pulse consume_done (bank0 ready) in the same cycle -> next cycle banks_full=1, rp_bank=1, rd_addr=3 returns word 4 of bank1.
- rd_en with rd_addr=5 while bank_ready=1 -> rd_data=0, err=1 sticky. Separately, consume_done while bank_ready=0 -> ignored, err=1.
- Assert rst_n low after 2 of 4 words -> load_ready=1, fill_count=0 asynchronously. Re-stream 4 words -> bank_ready=1 with only the new data readable.

Source files
------------

// File: rtl/fmap_pingpong_buffer_if.sv
// Producer/consumer bundle for the ping-pong feature-map buffer.
// The master modport is the producer plus conv2d engine side; slave is the buffer.
interface fmap_pingpong_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  bank_ready;
   logic                  consume_done;
   logic [ADDR_WIDTH-1:0] fill_count;
   logic [1:0]            banks_full;
   logic                  err;

   modport master (
      output load_valid, load_data, rd_en, rd_addr, consume_done,
      input  load_ready, rd_data, bank_ready, fill_count, banks_full, err
   );

   modport slave (
      input  load_valid, load_data, rd_en, rd_addr, consume_done,
      output load_ready, rd_data, bank_ready, fill_count, banks_full, err
   );
endinterface

// File: rtl/fmap_pingpong_buffer.sv
// Double-banked feature-map buffer: a stream producer fills one bank while a
// conv2d engine reads the other combinationally; banks swap on consume_done.
module fmap_pingpong_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fmap_pingpong_buffer_if.slave     bus
);

   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
   logic                  r_wp_bank;
   logic                  r_rp_bank;
   logic [1:0]            r_full;
   logic [IDX_W-1:0]      r_fill_cnt;
   logic                  r_err;

   logic                  w_load_ready;
   logic                  w_xfer;
   logic                  w_last;
   logic                  w_bank_ready;
   logic                  w_addr_ok;
   logic                  w_rd_hit;
   logic                  w_rd_err;
   logic                  w_consume;
   logic                  w_consume_err;
   logic [1:0]            w_full_nxt;

   // Handshake terms depend only on registered state, never on load_valid.
   assign w_load_ready  = ~r_full[r_wp_bank];
   assign w_xfer        = bus.load_valid & w_load_ready;
   assign w_last        = w_xfer & (r_fill_cnt == LAST_IDX);
   assign w_bank_ready  = r_full[r_rp_bank];
   assign w_addr_ok     = {1'b0, bus.rd_addr} < DEPTH_LIM;
   assign w_rd_hit      = bus.rd_en & w_bank_ready & w_addr_ok;
   assign w_rd_err      = bus.rd_en & ~(w_bank_ready & w_addr_ok);
   assign w_consume     = bus.consume_done & w_bank_ready;
   assign w_consume_err = bus.consume_done & ~w_bank_ready;

   // A completing fill and a consume always touch different banks, since the
   // fill bank is empty and the consume bank is full.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_full_nxt = r_full;
      if (w_consume) w_full_nxt[r_rp_bank] = 1'b0;
      if (w_last)    w_full_nxt[r_wp_bank] = 1'b1;
   end

   // NOTE: storage arrays carry no reset; only the control state below is cleared.
   always_ff @(posedge clk) begin
      if (w_xfer) r_mem[r_wp_bank][r_fill_cnt] <= bus.load_data;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp_bank  <= 1'b0;
         r_rp_bank  <= 1'b0;
         r_full     <= 2'b00;
         r_fill_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_xfer) begin
            if (w_last) begin
               r_fill_cnt <= '0;
               r_wp_bank  <= ~r_wp_bank;
            end else begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end
         if (w_consume) r_rp_bank <= ~r_rp_bank;
         r_full <= w_full_nxt;
         if (w_rd_err | w_consume_err) r_err <= 1'b1;
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.bank_ready = w_bank_ready;
   assign bus.rd_data    = w_rd_hit ? r_mem[r_rp_bank][bus.rd_addr[IDX_W-1:0]] : '0;
   assign bus.fill_count = ADDR_WIDTH'(r_fill_cnt);
   assign bus.banks_full = {1'b0, r_full[0]} + {1'b0, r_full[1]};
   assign bus.err        = r_err;

endmodule
